// File: rtl/reg_cmd_pkg.sv
// Shared types for the byte-register command sequencer.
package reg_cmd_pkg;

  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_INC, OP_ROR} reg_op_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} seq_state_t;

endpackage

// File: rtl/reg_cmd_sequencer.sv
// Expands one valid/ready command into per-cycle load/inc/rotate_right strobes
// for the byte register, with busy/done status back to the issuer.
//
// state   | meaning
// S_IDLE  | cmd_ready high, waiting for a command
// S_ISSUE | driving one strobe per cycle, busy high
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module reg_cmd_sequencer
  import reg_cmd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             load,
  output logic             inc,
  output logic             rotate_right,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done
);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] remaining;
  reg_op_t          op;
  logic             accept;

  assign op        = reg_op_t'(cmd_op);
  assign accept    = (state == S_IDLE) && cmd_valid;
  assign cmd_ready = (state == S_IDLE) && !reset;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_LOAD || ((op == OP_INC || op == OP_ROR) && cmd_count != '0))
            state_nxt = S_ISSUE;
          else
            state_nxt = S_DONE;
        end
      end
      S_ISSUE: if (remaining == 1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      remaining    <= '0;
      load         <= 1'b0;
      inc          <= 1'b0;
      rotate_right <= 1'b0;
      D            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_ISSUE);
      done  <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (accept && state_nxt == S_ISSUE) begin
            if (op == OP_LOAD) begin
              // A load is a single-strobe issue, so it reuses the count exit.
              load      <= 1'b1;
              D         <= cmd_data;
              remaining <= CNT_W'(1);
            end else begin
              inc          <= (op == OP_INC);
              rotate_right <= (op == OP_ROR);
              remaining    <= cmd_count;
            end
          end
        end
        S_ISSUE: begin
          remaining <= remaining - 1'b1;
          if (remaining == 1) begin
            load         <= 1'b0;
            inc          <= 1'b0;
            rotate_right <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Randomized and directed bench for reg_cmd_sequencer against a queue-based
// model of the per-cycle output schedule each command produces.
module tb_reg_cmd_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] cmd_count;
  logic       load, inc, rotate_right, busy, done;
  logic [7:0] D;

  int errors = 0;
  int checks = 0;

  reg_cmd_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .load(load), .inc(inc), .rotate_right(rotate_right), .D(D),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // attached byte register
  logic [7:0] q_reg = 8'h00;
  always @(posedge clk) begin
    if (load)              q_reg <= D;
    else if (inc)          q_reg <= q_reg + 8'd1;
    else if (rotate_right) q_reg <= {q_reg[0], q_reg[7:1]};
  end

  // model: each accepted command becomes a list of output slots, one per cycle
  typedef struct packed {
    logic       ld;
    logic       in;
    logic       rr;
    logic       bz;
    logic       dn;
    logic [7:0] d;
  } slot_t;

  slot_t      sched[$];
  slot_t      cur = '0;
  logic [7:0] exp_d = 8'h00;
  bit         model_on = 0;

  function automatic bit model_idle();
    return (sched.size() == 0) && (cur == '0);
  endfunction

  always @(posedge clk) begin
    slot_t s;
    if (reset) begin
      sched.delete();
      cur      = '0;
      exp_d    = 8'h00;
      model_on = 1;
    end else begin
      if (model_on && model_idle() && cmd_valid) begin
        if (cmd_op == 2'b01) begin
          s = '0; s.ld = 1; s.bz = 1; s.d = cmd_data;
          sched.push_back(s);
        end else if (cmd_op != 2'b00) begin
          for (int i = 0; i < cmd_count; i++) begin
            s = '0; s.in = (cmd_op == 2'b10); s.rr = (cmd_op == 2'b11); s.bz = 1;
            sched.push_back(s);
          end
        end
        s = '0; s.dn = 1;
        sched.push_back(s);
      end
      cur = (sched.size() > 0) ? sched.pop_front() : slot_t'('0);
      if (cur.ld) exp_d = cur.d;
    end
  end

  int  ld_cnt, in_cnt, rr_cnt, dn_cnt;
  bit  busy_seen;

  always @(negedge clk) begin
    if (model_on) begin
      chk("load", load, cur.ld);
      chk("inc", inc, cur.in);
      chk("rotate_right", rotate_right, cur.rr);
      chk("busy", busy, cur.bz);
      chk("done", done, cur.dn);
      chk("D", D, exp_d);
      chk("cmd_ready", cmd_ready, model_idle() && !reset);
      chk("onehot", (32'(load) + 32'(inc) + 32'(rotate_right)) <= 1, 1);
    end
    ld_cnt += 32'(load);
    in_cnt += 32'(inc);
    rr_cnt += 32'(rotate_right);
    dn_cnt += 32'(done);
    if (busy) busy_seen = 1;
  end

  task automatic clear_mon();
    ld_cnt = 0; in_cnt = 0; rr_cnt = 0; dn_cnt = 0; busy_seen = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // returns after the accept edge, i.e. in the first cycle after accept
  task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                      output int waited);
    logic acc;
    cmd_valid = 1; cmd_op = op; cmd_data = data; cmd_count = cnt;
    acc = 0; waited = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #2;
      waited++;
    end
    cmd_valid = 0;
    cmd_data  = 8'($urandom);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_count = 0;
    clear_mon();
    run(2);
    reset = 0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_D", D, 0);
    chk("rst_busy", busy, 0);
    run(1);

    clear_mon();
    send(2'b01, 8'hA5, 4'd0, w);
    run(3);
    chk("load_cycles", ld_cnt, 1);
    chk("load_done", dn_cnt, 1);
    chk("load_D", D, 8'hA5);
    chk("load_Q", q_reg, 8'hA5);

    clear_mon();
    send(2'b10, 8'h00, 4'd3, w);
    run(5);
    chk("inc3_cycles", in_cnt, 3);
    chk("inc3_done", dn_cnt, 1);
    chk("inc3_Q", q_reg, 8'hA8);

    clear_mon();
    send(2'b11, 8'h00, 4'd0, w);
    run(3);
    send(2'b00, 8'h00, 4'd7, w);
    run(3);
    chk("zero_busy", busy_seen, 0);
    chk("zero_done", dn_cnt, 2);
    chk("zero_strobes", ld_cnt + in_cnt + rr_cnt, 0);

    clear_mon();
    send(2'b10, 8'h00, 4'd15, w);
    run(18);
    chk("inc15_cycles", in_cnt, 15);
    chk("inc15_done", dn_cnt, 1);
    chk("inc15_Q", q_reg, 8'hB7);

    clear_mon();
    send(2'b11, 8'h00, 4'd5, w);
    run(1);
    reset = 1;
    run(1);
    reset = 0;
    @(negedge clk);
    chk("midrst_ror", rotate_right, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    run(3);
    chk("midrst_ror_cnt", rr_cnt, 2);
    chk("midrst_no_done", dn_cnt, 0);

    clear_mon();
    reset = 1; cmd_valid = 1; cmd_op = 2'b01; cmd_data = 8'h3C;
    run(1);
    reset = 0; cmd_valid = 0;
    run(3);
    chk("rstvalid_load", ld_cnt, 0);
    chk("rstvalid_done", dn_cnt, 0);

    send(2'b11, 8'h00, 4'd4, w);
    clear_mon();
    send(2'b10, 8'h00, 4'd2, w);
    chk("held_wait", w, 6);
    chk("held_ror", rr_cnt, 4);
    chk("held_no_inc", in_cnt, 0);
    run(4);
    chk("held_inc", in_cnt, 2);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        reset = 1;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op = 2'($urandom);
        run(1);
        reset = 0; cmd_valid = 0;
      end
      send(2'($urandom), 8'($urandom), 4'($urandom), w);
      run($urandom_range(0, 20));
    end
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
